// File: rtl/wb_regfile_if.sv
// wb_regfile_if: EX/WB write-back, decode read and EX forwarding signals of the register file
interface wb_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] wb_rd, ra1, ra2, ex_rs1, ex_rs2;
    logic [DATA_W-1:0] wb_ext_data, wb_aluout, rd1, rd2, wb_data;
    logic              wb_regwrite, wb_wbsel, fwd1_hit, fwd2_hit;
    logic [CNT_W-1:0]  wr_count;
    modport master (
        output wb_rd, wb_ext_data, wb_aluout, wb_regwrite, wb_wbsel, ra1, ra2, ex_rs1, ex_rs2,
        input  rd1, rd2, wb_data, fwd1_hit, fwd2_hit, wr_count
    );
    modport slave (
        input  wb_rd, wb_ext_data, wb_aluout, wb_regwrite, wb_wbsel, ra1, ra2, ex_rs1, ex_rs2,
        output rd1, rd2, wb_data, fwd1_hit, fwd2_hit, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, register file, forwarding match and saturating write counter
// Define WB_BYPASS_EN for same-cycle write-through on the decode read ports.
module wb_regfile #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1,
    parameter int CNT_W   = 16
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int N = 1 << ADDR_W;
    logic [DATA_W-1:0] regs [N];
    logic [CNT_W-1:0]  cnt;
    logic              we, r0_dst;
    assign r0_dst       = (ZERO_R0 != 0) && (bus.wb_rd == '0);
    assign we           = bus.wb_regwrite && !r0_dst;
    assign bus.wb_data  = bus.wb_wbsel ? bus.wb_ext_data : bus.wb_aluout;
    assign bus.fwd1_hit = we && (bus.ex_rs1 == bus.wb_rd);
    assign bus.fwd2_hit = we && (bus.ex_rs2 == bus.wb_rd);
    assign bus.wr_count = cnt;
    // Bypass is gated by rst so reads stay 0 throughout reset.
    assign bus.rd1 = ((ZERO_R0 != 0) && (bus.ra1 == '0)) ? '0 :
                     (BYPASS && rst && we && (bus.ra1 == bus.wb_rd)) ? bus.wb_data : regs[bus.ra1];
    assign bus.rd2 = ((ZERO_R0 != 0) && (bus.ra2 == '0)) ? '0 :
                     (BYPASS && rst && we && (bus.ra2 == bus.wb_rd)) ? bus.wb_data : regs[bus.ra2];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            cnt <= '0;
        end else if (we) begin
            regs[bus.wb_rd] <= bus.wb_data;
            if (cnt != '1) cnt <= cnt + 1'b1;
        end
    end
endmodule
